hex_scan_display: RTL and testbench

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

---
 rtl/sseg_pkg.sv | 34 +++
 rtl/sseg_glyph.sv | 17 +
 rtl/hex_scan_display.sv | 192 +++++++++++++++++++
 tb/tb_hex_scan_display.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the multiplexed seven-segment display.
//   seg_t      : 7-bit active-low segment vector, bit0=a (top), clockwise
//                through bit5=f, bit6=g (middle).
//   SEG_OFF    : all segments dark.
//   HEX_GLYPH  : active-low glyphs for nibbles 0-F (b and d lowercase).
// ---------------------------------------------------------------------------
package sseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t HEX_GLYPH [16] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10,  // 9
        7'h08,  // A
        7'h03,  // b
        7'h46,  // C
        7'h21,  // d
        7'h06,  // E
        7'h0E   // F
    };

endpackage

// File: rtl/sseg_glyph.sv
// ---------------------------------------------------------------------------
// sseg_glyph
// Purely combinational hex-to-seven-segment decoder.
// Ports:
//   i_nibble : 4-bit hex value to display
//   o_seg    : active-low segment pattern for that value
// ---------------------------------------------------------------------------
module sseg_glyph
    import sseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    assign o_seg = HEX_GLYPH[i_nibble];

endmodule

// File: rtl/hex_scan_display.sv
// ---------------------------------------------------------------------------
// hex_scan_display
// Time-multiplexed driver for NUM_DIGITS common-anode hex digits. Each digit
// owns a slot of SCAN_DIV clocks; the first clock of every slot is dead time
// so the previous digit's segments never ghost onto the next one. A new value
// is accepted into a pending buffer and only shown from the next frame wrap,
// so a frame is never torn between two values.
//
// Optional feature macro: SSEG_BLINK_EN adds the BLINK_DIV parameter, the
// blink_mask input and a frame-based blink phase.
//
// Ports:
//   clk          : sole clock, rising edge
//   reset_n      : asynchronous active-low reset
//   load_valid   : new display value offered
//   load_data    : NUM_DIGITS hex nibbles, nibble k = digit k
//   load_ready   : pending buffer empty (load accepted on valid & ready)
//   enable       : display on/off, scanning and loading keep running
//   lz_blank     : leading-zero suppression
//   blink_mask   : per-digit blink select (SSEG_BLINK_EN only)
//   digit_sel_n  : active-low one-hot digit select
//   segments     : active-low segments
//   frame_done   : one-cycle pulse after each frame wrap
// ---------------------------------------------------------------------------
module hex_scan_display
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024
`ifdef SSEG_BLINK_EN
    ,
    parameter int BLINK_DIV  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    input  logic                    enable,
    input  logic                    lz_blank,
`ifdef SSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output seg_t                    segments,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [PRE_W-1:0]        r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_full;
    logic [NUM_DIGITS-1:0]   r_digitSel;
    seg_t                    r_segments;
    logic                    r_frameDone;

    logic                    w_tc;
    logic                    w_wrap;
    logic [3:0]              w_nibble;
    seg_t                    w_glyph;
    logic [NUM_DIGITS-1:0]   w_lzMask;
    logic                    w_seen;
    logic                    w_blank;
    logic                    w_blinkOff;

    assign w_tc   = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_wrap = w_tc && (r_idx == IDX_W'(NUM_DIGITS - 1));

    // Slot timing: the prescaler counts through one digit slot and the digit
    // index advances on its terminal count, wrapping back to digit 0 to start
    // a new frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Load handshake: one pending slot. On a wrap edge a full pending buffer
    // is committed and freed; since ready is low while it is full, a load
    // accepted on a wrap edge can only land in an empty buffer and so waits
    // for the following wrap to be committed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp <= '0;
            r_pend <= '0;
            r_full <= 1'b0;
        end else if (w_wrap && r_full) begin
            r_disp <= r_pend;
            r_full <= 1'b0;
        end else if (load_valid && !r_full) begin
            r_pend <= load_data;
            r_full <= 1'b1;
        end
    end

    assign load_ready = ~r_full;

    // Pick the nibble belonging to the digit currently being scanned.
    always_comb begin
        w_nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble = r_disp[4*k +: 4];
            end
        end
    end

    sseg_glyph u_glyph (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    // Leading-zero map: walking down from the most significant digit, a digit
    // is suppressible until the first nonzero nibble is seen. Digit 0 always
    // shows so a zero value still reads "0".
    always_comb begin
        w_seen   = 1'b0;
        w_lzMask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (r_disp[4*k +: 4] != 4'h0) begin
                w_seen = 1'b1;
            end
            w_lzMask[k] = ~w_seen;
        end
    end

    assign w_blank = lz_blank & w_lzMask[r_idx];

`ifdef SSEG_BLINK_EN
    localparam int BL_W = $clog2(BLINK_DIV + 1);

    logic [BL_W-1:0] r_blinkCnt;
    logic            r_blinkPhase;

    // Blink phase: flips after every BLINK_DIV frame wraps, so blinking
    // digits stay dark for BLINK_DIV frames and lit for BLINK_DIV frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (w_wrap) begin
            if (r_blinkCnt == BL_W'(BLINK_DIV - 1)) begin
                r_blinkCnt   <= '0;
                r_blinkPhase <= ~r_blinkPhase;
            end else begin
                r_blinkCnt <= r_blinkCnt + 1'b1;
            end
        end
    end

    assign w_blinkOff = r_blinkPhase & blink_mask[r_idx];
`else
    assign w_blinkOff = 1'b0;
`endif

    // Output stage: everything leaves through registers so the pins update on
    // the same edge as the index. The terminal-count edge loads the dead-time
    // pattern, giving an all-dark first cycle in every slot. A blinked or
    // blanked digit keeps its select asserted with segments dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digitSel  <= '1;
            r_segments  <= SEG_OFF;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_wrap;
            if (!enable || w_tc) begin
                r_digitSel <= '1;
                r_segments <= SEG_OFF;
            end else begin
                r_digitSel <= ~(NUM_DIGITS'(1) << r_idx);
                r_segments <= (w_blank || w_blinkOff) ? SEG_OFF : w_glyph;
            end
        end
    end

    assign digit_sel_n = r_digitSel;
    assign segments    = r_segments;
    assign frame_done  = r_frameDone;

endmodule

// File: tb/tb_hex_scan_display.sv
// ---------------------------------------------------------------------------
// tb_hex_scan_display
// Scoreboard bench for hex_scan_display (NUM_DIGITS=4, SCAN_DIV=4,
// BLINK_DIV=2). The stimulus process drives inputs each cycle and pushes the
// outputs it expects for the next cycle, derived from cycle arithmetic since
// reset release; a monitor pops and compares on every falling edge.
// Honours SSEG_BLINK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_hex_scan_display;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BD = 2;
    localparam int FR = ND * SD;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        enable;
    logic        lz_blank;
    logic [3:0]  blink_mask;
    logic [3:0]  digit_sel_n;
    logic [6:0]  segments;
    logic        frame_done;

    always #5 clk = ~clk;

    hex_scan_display #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD)
`ifdef SSEG_BLINK_EN
        ,
        .BLINK_DIV  (BD)
`endif
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .enable      (enable),
        .lz_blank    (lz_blank),
`ifdef SSEG_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .digit_sel_n (digit_sel_n),
        .segments    (segments),
        .frame_done  (frame_done)
    );

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       fd;
        logic       rdy;
        int         cyc;
    } exp_t;

    exp_t sbQ [$];

    int vectors     = 0;
    int miscompares = 0;
    bit inReset     = 1'b1;

    // Reference glyphs for 0-F, active-low gfedcba.
    logic [6:0] glyphTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model state: t is the cycle index since reset release.
    int          t;
    logic [15:0] mDisp;
    logic [15:0] mPend;
    bit          mFull;
    logic        pV;
    logic [15:0] pD;
    logic        pE;
    logic        pL;
    logic [3:0]  pB;

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        return v[4*k +: 4];
    endfunction

    function automatic void checkOutput(input string name, input logic [31:0] act,
                                        input logic [31:0] reqd, input int cyc);
        vectors++;
        if (act !== reqd) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, reqd);
        end
    endfunction

    // Expected outputs of cycle t, using the inputs sampled in cycle t-1.
    task automatic pushExpected();
        exp_t e;
        int   pos;
        int   dig;
        int   hi;
        bit   off;
        e.cyc = t;
        e.fd  = (t > 0) && (t % FR == 0);
        e.rdy = !mFull;
        e.sel = 4'hF;
        e.seg = 7'h7F;
        pos   = t % SD;
        dig   = (t / SD) % ND;
        if (t > 0 && pE && pos != 0) begin
            e.sel = ~(4'b0001 << dig);
            hi = 0;
            for (int k = 0; k < ND; k++) begin
                if (nib(mDisp, k) != 4'h0) hi = k;
            end
            off = 1'b0;
`ifdef SSEG_BLINK_EN
            off = (((t / FR) / BD) % 2 == 1) && pB[dig];
`endif
            if ((pL && dig > hi) || off) e.seg = 7'h7F;
            else                         e.seg = glyphTab[nib(mDisp, dig)];
        end
        sbQ.push_back(e);
    endtask

    // Close cycle t with its inputs, then predict cycle t+1.
    task automatic stepModel();
        bit wrapEdge;
        wrapEdge = (t % FR) == FR - 1;
        if (wrapEdge && mFull) begin
            mDisp = mPend;
            mFull = 1'b0;
        end else if (pV && !mFull) begin
            mPend = pD;
            mFull = 1'b1;
        end
        t++;
        pushExpected();
    endtask

    task automatic startModel();
        t     = 0;
        mDisp = '0;
        mPend = '0;
        mFull = 1'b0;
        pushExpected();
    endtask

    // validMode: 0 always, 1 random, 2 only in the last cycle of a frame, 3 never.
    // lzMode: 0 off, 1 on, 2 random.
    task automatic applyStimulus(input int n, input logic [15:0] data, input bit randData,
                                 input int validMode, input int lzMode, input bit randEn);
        for (int i = 0; i < n; i++) begin
            case (validMode)
                0:       pV = 1'b1;
                1:       pV = 1'($urandom_range(0, 1));
                2:       pV = ((t % FR) == FR - 1);
                default: pV = 1'b0;
            endcase
            pD = randData ? 16'($urandom) : data;
            pL = (lzMode == 2) ? 1'($urandom_range(0, 1)) : (lzMode == 1);
            pE = randEn ? ($urandom_range(0, 7) != 0) : 1'b1;
            pB = randData ? 4'($urandom) : 4'b0010;
            load_valid = pV;
            load_data  = pD;
            lz_blank   = pL;
            enable     = pE;
            blink_mask = pB;
            @(posedge clk);
            #2;
            stepModel();
        end
    endtask

    task automatic checkResetState(input int cyc);
        checkOutput("rst_digit_sel_n", 32'(digit_sel_n), 32'h0000_000F, cyc);
        checkOutput("rst_segments",    32'(segments),    32'h0000_007F, cyc);
        checkOutput("rst_load_ready",  32'(load_ready),  32'h0000_0001, cyc);
        checkOutput("rst_frame_done",  32'(frame_done),  32'h0000_0000, cyc);
    endtask

    // Asynchronous reset in the middle of a cycle, then restart the model.
    task automatic midReset();
        @(posedge clk);
        #4;
        reset_n = 1'b0;
        inReset = 1'b1;
        sbQ.delete();
        #1;
        checkResetState(t);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        inReset = 1'b0;
        startModel();
    endtask

    // Monitor: compare the DUT against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!inReset) begin
                if (sbQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL scoreboard_underflow at t=%0d: got no entry, expected one", t);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("digit_sel_n", 32'(digit_sel_n), 32'(e.sel), e.cyc);
                    checkOutput("segments",    32'(segments),    32'(e.seg), e.cyc);
                    checkOutput("frame_done",  32'(frame_done),  32'(e.fd),  e.cyc);
                    checkOutput("load_ready",  32'(load_ready),  32'(e.rdy), e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n    = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        enable     = 1'b1;
        lz_blank   = 1'b0;
        blink_mask = '0;
        pV = 1'b0; pD = '0; pE = 1'b1; pL = 1'b0; pB = '0;
        #3;
        reset_n = 1'b0;
        #1;
        checkResetState(0);
        repeat (3) @(posedge clk);
        #2;
        checkResetState(0);
        reset_n = 1'b1;
        inReset = 1'b0;
        startModel();
        $display("[TB] reset released, starting directed phases");

        applyStimulus(80, 16'h12A0, 1'b0, 0, 0, 1'b0);
        applyStimulus(64, 16'h0030, 1'b0, 0, 1, 1'b0);
        applyStimulus(64, 16'h0000, 1'b0, 0, 1, 1'b0);

        applyStimulus(40, 16'h0000, 1'b0, 3, 0, 1'b0);
        applyStimulus(1,  16'h1111, 1'b0, 0, 0, 1'b0);
        applyStimulus(48, 16'h2222, 1'b0, 0, 0, 1'b0);

        applyStimulus(40, 16'h0000, 1'b0, 3, 0, 1'b0);
        applyStimulus(80, 16'h0000, 1'b1, 2, 0, 1'b0);

        $display("[TB] random phases");
        applyStimulus(300, 16'h0000, 1'b1, 1, 2, 1'b1);
        midReset();
        applyStimulus(200, 16'h0000, 1'b1, 1, 2, 1'b1);
        midReset();
        applyStimulus(60, 16'h0000, 1'b1, 1, 2, 1'b0);

        @(negedge clk);
        #1;
        checkOutput("scoreboard_drain", 32'(sbQ.size()), 32'd0, t);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
